// File: rtl/rename_free_list.sv
// Circular free list of physical register numbers for the rename stage.
// Multi-lane pop/push with compacted lanes, no bypass and sticky error flags.
module rename_free_list #(
  parameter int ENTRY_NUM      = 32,
  parameter int RENAME_WIDTH   = 2,
  parameter int PREG_BIT_WIDTH = 6,
  parameter int INIT_BASE      = 32
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [RENAME_WIDTH-1:0]                      popReq,
  output logic [RENAME_WIDTH-1:0][PREG_BIT_WIDTH-1:0]  popPhyReg,
  input  logic [RENAME_WIDTH-1:0]                      pushReq,
  input  logic [RENAME_WIDTH-1:0][PREG_BIT_WIDTH-1:0]  pushPhyReg,
  output logic [$clog2(ENTRY_NUM):0]                   count,
  output logic                                         allocatable,
  output logic                                         full,
  output logic                                         errOverflow,
  output logic                                         errUnderflow
);

  localparam int PTR_W = $clog2(ENTRY_NUM);
  localparam int CNT_W = PTR_W + 1;
  localparam int EW    = CNT_W + 1;

  logic [PREG_BIT_WIDTH-1:0] entries_q [ENTRY_NUM];
  logic [PREG_BIT_WIDTH-1:0] entries_d [ENTRY_NUM];
  logic [PTR_W-1:0]          head_q, head_d;
  logic [PTR_W-1:0]          tail_q, tail_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      err_ovf_q, err_ovf_d;
  logic                      err_udf_q, err_udf_d;

  logic [CNT_W-1:0]          pop_pre, push_pre;
  logic [CNT_W-1:0]          pops_acc, pushes_acc;
  logic [EW-1:0]             net_cnt;
  logic                      pop_ok, push_ok;

  // Pointer add modulo ENTRY_NUM; n never exceeds RENAME_WIDTH so one subtract suffices.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [CNT_W-1:0] n);
    logic [EW-1:0] s;
    s = {2'b00, p} + {1'b0, n};
    if (s >= EW'(ENTRY_NUM)) s = s - EW'(ENTRY_NUM);
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    pop_pre = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      popPhyReg[i] = entries_q[ptr_add(head_q, pop_pre)];
      if (popReq[i]) pop_pre = pop_pre + CNT_W'(1);
    end

    pop_ok   = (pop_pre <= count_q);
    pops_acc = pop_ok ? pop_pre : '0;

    push_pre = '0;
    for (int i = 0; i < RENAME_WIDTH; i++)
      if (pushReq[i]) push_pre = push_pre + CNT_W'(1);

    // Push legality is judged after the accepted pops leave, never against new pushes.
    net_cnt    = EW'(count_q) - EW'(pops_acc) + EW'(push_pre);
    push_ok    = (net_cnt <= EW'(ENTRY_NUM));
    pushes_acc = push_ok ? push_pre : '0;

    entries_d = entries_q;
    if (push_ok) begin
      for (int i = 0; i < RENAME_WIDTH; i++) begin
        if (pushReq[i]) entries_d[ptr_add(tail_q, CNT_W'(popcnt_below(pushReq, i)))] = pushPhyReg[i];
      end
    end

    head_d    = ptr_add(head_q, pops_acc);
    tail_d    = ptr_add(tail_q, pushes_acc);
    count_d   = CNT_W'(EW'(count_q) - EW'(pops_acc) + EW'(pushes_acc));
    err_udf_d = err_udf_q | ~pop_ok;
    err_ovf_d = err_ovf_q | ~push_ok;
  end

  function automatic int popcnt_below(input logic [RENAME_WIDTH-1:0] v, input int lane);
    int c;
    c = 0;
    for (int j = 0; j < RENAME_WIDTH; j++)
      if (j < lane && v[j]) c++;
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ENTRY_NUM; k++) entries_q[k] <= PREG_BIT_WIDTH'(INIT_BASE + k);
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= CNT_W'(ENTRY_NUM);
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign count        = count_q;
  assign allocatable  = (count_q >= CNT_W'(RENAME_WIDTH));
  assign full         = (count_q == CNT_W'(ENTRY_NUM));
  assign errOverflow  = err_ovf_q;
  assign errUnderflow = err_udf_q;

endmodule

// File: doc/rename_free_list.md
RENAME_FREE_LIST -- requirements
Module: rename_free_list

Interface
REQ-001 SHALL provide parameter ENTRY_NUM, default 32, number of free-list entries (physical scalar registers minus logical scalar registers).
REQ-002 SHALL provide parameter RENAME_WIDTH, default 2, number of pop lanes and push lanes per cycle.
REQ-003 SHALL provide parameter PREG_BIT_WIDTH, default 6, width of a physical register number.
REQ-004 SHALL provide parameter INIT_BASE, default 32, first physical register number loaded at reset.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 popReq  input  RENAME_WIDTH  per-lane allocation request from rename.
REQ-008 popPhyReg  output  RENAME_WIDTH x PREG_BIT_WIDTH  allocated physical register per lane.
REQ-009 pushReq  input  RENAME_WIDTH  per-lane release request from commit.
REQ-010 pushPhyReg  input  RENAME_WIDTH x PREG_BIT_WIDTH  released physical register per lane.
REQ-011 count  output  clog2(ENTRY_NUM)+1  number of valid entries.
REQ-012 allocatable  output  1  high when count >= RENAME_WIDTH.
REQ-013 full  output  1  high when count == ENTRY_NUM.
REQ-014 errOverflow, errUnderflow  output  1 each  sticky error flags.

Function
REQ-015 SHALL store entries in a circular buffer of ENTRY_NUM entries with head (pop) and tail (push) pointers of clog2(ENTRY_NUM) bits; pointers wrap modulo ENTRY_NUM.
REQ-016 SHALL compact lanes: the pop lane i takes entry at head + (number of set popReq lanes below i); the push lane i writes entry at tail + (number of set pushReq lanes below i).
REQ-017 SHALL drive popPhyReg combinationally from storage in the same cycle as popReq; lanes with popReq low still show their would-be value, which is don't-care.
REQ-018 SHALL advance head by popcount(popReq) and tail by popcount(pushReq) at the clock edge; count' = count - pops + pushes.
REQ-019 SHALL evaluate pop and push against the pre-edge count, with no bypass: an entry pushed in cycle N is poppable no earlier than cycle N+1.
REQ-020 Simultaneous pop and push in one cycle SHALL both take effect, including when count == 0 with pushes only, or count == ENTRY_NUM with pops only.
REQ-021 If popcount(popReq) > count, the block SHALL ignore all pops that cycle (head unchanged), still apply valid pushes, and set errUnderflow.
REQ-022 If count - accepted pops + popcount(pushReq) > ENTRY_NUM, the block SHALL ignore all pushes that cycle (tail unchanged), still apply valid pops, and set errOverflow.
REQ-023 Rename SHALL only assert popReq when allocatable is high; commit never pushes more registers than were popped.
REQ-024 Error flags SHALL remain set until reset.

Reset
REQ-025 On rst high at a clock edge, the block SHALL set entry k to INIT_BASE + k for k = 0..ENTRY_NUM-1, head = 0, tail = 0, count = ENTRY_NUM, full = 1, allocatable = 1, and both error flags to 0.
REQ-026 Reset SHALL override any popReq or pushReq in the same cycle.
REQ-027 Reset asserted mid-operation SHALL fully discard prior contents and pointers.

Verification
REQ-028 Reset, then popReq=2'b11 -> popPhyReg={33,32} (lane1, lane0) that cycle; next cycle count=30, full=0.
REQ-029 After reset, popReq=2'b10 -> lane1 receives 32; next cycle head=1, count=31.
REQ-030 After reset, pushReq=2'b01 with 5 and no pop -> push ignored, errOverflow=1, count stays 32.
REQ-031 16 cycles of popReq=2'b11 -> count=0, allocatable=0, head wrapped to 0; then pushReq=2'b11 {7,5} -> count=2; next popReq=2'b11 -> popPhyReg={7,5}.
REQ-032 count=1, popReq=2'b11 with pushReq=2'b01 (9) -> pops ignored, errUnderflow=1, count=2.
REQ-033 count=1, popReq=2'b01 with pushReq=2'b01 (9) in the same cycle -> lane0 gets the old entry (not 9), count stays 1; next cycle pop returns 9.
